param_sync_fifo: RTL

Single-clock, fully parametrised synchronous FIFO. It is the next generation of the team's basic FIFO. It adds:
- non-power-of-two depth
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- an occupancy count
- single-cycle and sticky overflow/underflow error reporting

It sits between producer and consumer blocks in the datapath and is the FIFO the UVM environment targets going forward.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_mem.sv | 38 +++
 rtl/param_sync_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helper functions for param_sync_fifo and fifo_mem.
//   FIFO_STD / FIFO_FWFT   : read-mode selectors for the FWFT parameter
//   FIFO_DEF_AE_THRESH     : default almost-empty threshold
//   FIFO_DEF_AF_MARGIN     : default almost-full threshold is DEPTH minus this
//   fifo_count_width()     : width of an occupancy counter that can hold DEPTH
//   fifo_addr_width()      : width of a pointer indexing 0..DEPTH-1
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_STD           = 0;
    localparam int FIFO_FWFT          = 1;
    localparam int FIFO_DEF_AE_THRESH = 2;
    localparam int FIFO_DEF_AF_MARGIN = 2;

    // Occupancy runs 0..DEPTH inclusive, so DEPTH+1 distinct values.
    function automatic int fifo_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer runs 0..DEPTH-1; never narrower than one bit.
    function automatic int fifo_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// WIDTH x DEPTH register-array storage: one synchronous write port and an
// asynchronous (combinational) read address. Contents are never reset.
//   clk        : clock, write happens on the rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write address (0..DEPTH-1)
//   i_wr_data  : write data
//   i_rd_addr  : read address (0..DEPTH-1)
//   o_rd_data  : word stored at i_rd_addr
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = fifo_addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Callers keep the address below DEPTH, so every index hits a real entry.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
// Single-clock synchronous FIFO with arbitrary depth, standard or
// first-word-fall-through read mode, almost-full/empty thresholds, an
// occupancy count and pulsed + sticky overflow/underflow reporting.
//   clk              : clock (rising edge)
//   rst              : synchronous active-low reset
//   data_in / wr_en  : write data and request
//   rd_en            : read request
//   err_clr          : clears overflow_sticky / underflow_sticky
//   data_out         : read data
//   rd_valid         : data_out carries newly read (STD) or presented (FWFT) data
//   full / empty     : count == DEPTH / count == 0
//   almost_full      : count >= AF_THRESH
//   almost_empty     : count <= AE_THRESH
//   count            : occupancy
//   write_error      : one-cycle pulse, a write was rejected last cycle
//   read_error       : one-cycle pulse, a read was rejected last cycle
//   overflow_sticky  : latched write rejection
//   underflow_sticky : latched read rejection
// ---------------------------------------------------------------------------
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = FIFO_STD,
    parameter int AF_THRESH = DEPTH - FIFO_DEF_AF_MARGIN,
    parameter int AE_THRESH = FIFO_DEF_AE_THRESH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0]                   data_in,
    input  logic                               wr_en,
    input  logic                               rd_en,
    input  logic                               err_clr,
    output logic [WIDTH-1:0]                   data_out,
    output logic                               rd_valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [fifo_count_width(DEPTH)-1:0] count,
    output logic                               write_error,
    output logic                               read_error,
    output logic                               overflow_sticky,
    output logic                               underflow_sticky
);

    localparam int CW = fifo_count_width(DEPTH);
    localparam int AW = fifo_addr_width(DEPTH);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C      = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C      = CW'(AE_THRESH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_write_error;
    logic             r_read_error;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_wr_rej;
    logic             w_rd_rej;
    logic [WIDTH-1:0] w_rd_data;

    // Flags come from the registered count only, never from the requests.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A full FIFO still takes a write when a read frees a slot this cycle.
    // An empty FIFO never reads the word being written (no bypass).
    assign w_rd_acc = rd_en && !w_empty;
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc);
    assign w_wr_rej = wr_en && !w_wr_acc;
    assign w_rd_rej = rd_en && !w_rd_acc;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pulses report the previous cycle's rejection. Sticky flags latch the
    // rejection on the same edge as the pulse; a new error beats err_clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_write_error <= 1'b0;
            r_read_error  <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_write_error <= w_wr_rej;
            r_read_error  <= w_rd_rej;
            r_overflow    <= w_wr_rej || (r_overflow && !err_clr);
            r_underflow   <= w_rd_rej || (r_underflow && !err_clr);
        end
    end

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            logic [WIDTH-1:0] r_last;

            // Head word is shown straight from storage; r_last remembers it
            // so data_out holds steady once the FIFO drains.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_last <= '0;
                end else if (!w_empty) begin
                    r_last <= w_rd_data;
                end
            end

            assign data_out = w_empty ? r_last : w_rd_data;
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_data_out;
            logic             r_rd_valid;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_data_out <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= w_rd_data;
                    end
                end
            end

            assign data_out = r_data_out;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full             = w_full;
    assign empty            = w_empty;
    assign almost_full      = (r_count >= AF_C);
    assign almost_empty     = (r_count <= AE_C);
    assign count            = r_count;
    assign write_error      = r_write_error;
    assign read_error       = r_read_error;
    assign overflow_sticky  = r_overflow;
    assign underflow_sticky = r_underflow;

endmodule
